// File: rtl/mem_arbiter.sv
// Arbitrates one shared SRAM port between instruction fetch and data access.
// Define MEM_ARBITER_DATA_PRIORITY_EN for fixed data priority instead of round-robin.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_valid,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  typedef enum logic [1:0] {
    IDLE,
    IF_ACC,
    DM_ACC
  } state_t;

  localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_last_dm;
  logic       w_gnt_if;
  logic       w_gnt_dm;

`ifdef MEM_ARBITER_DATA_PRIORITY_EN
  assign w_gnt_dm = dm_req;
  assign w_gnt_if = if_req & ~dm_req;
`else
  // Fetch wins a tie only when data was served last.
  assign w_gnt_if = if_req & (~dm_req | r_last_dm);
  assign w_gnt_dm = dm_req & ~w_gnt_if;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_last_dm <= 1'b1;
      if_rdata  <= 32'd0;
      dm_rdata  <= 32'd0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      mem_cs    <= 1'b0;
      mem_oe    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= 32'd0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_cnt <= 4'd0;
          if (w_gnt_if) begin
            r_state   <= IF_ACC;
            r_last_dm <= 1'b0;
            mem_cs    <= 1'b1;
            mem_oe    <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_din   <= 32'd0;
          end else if (w_gnt_dm) begin
            r_state   <= DM_ACC;
            r_last_dm <= 1'b1;
            mem_cs    <= 1'b1;
            mem_oe    <= ~dm_we;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_din   <= dm_we ? dm_wdata : 32'd0;
          end
        end
        IF_ACC, DM_ACC: begin
          if (r_cnt == LAST) begin
            if (r_state == IF_ACC) begin
              if_rdata <= mem_dout;
              if_valid <= 1'b1;
            end else begin
              if (!mem_we) dm_rdata <= mem_dout;
              dm_valid <= 1'b1;
            end
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            mem_cs   <= 1'b0;
            mem_oe   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (MEM_LAT=3).
module tb_mem_arbiter;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        mem_cs;
  logic        mem_oe;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W (32),
    .MEM_LAT(LAT)
  ) u_dut (
    .clk     (clk),
    .reset   (reset),
    .if_req  (if_req),
    .if_addr (if_addr),
    .if_rdata(if_rdata),
    .if_valid(if_valid),
    .dm_req  (dm_req),
    .dm_we   (dm_we),
    .dm_addr (dm_addr),
    .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata),
    .dm_valid(dm_valid),
    .mem_cs  (mem_cs),
    .mem_oe  (mem_oe),
    .mem_we  (mem_we),
    .mem_addr(mem_addr),
    .mem_din (mem_din),
    .mem_dout(mem_dout)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    check({tag, "_ctl"}, {if_valid, dm_valid, mem_cs, mem_oe, mem_we}, 5'b0);
    check({tag, "_bus"}, {mem_addr, mem_din}, 64'd0);
  endtask

  logic [1:0]  exp_seq [4];
  logic [31:0] w_exp_addr;
  logic        seen_valid;

  initial begin
`ifdef MEM_ARBITER_DATA_PRIORITY_EN
    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01};
`endif
    reset    = 1'b1;
    if_req   = 1'b0;
    if_addr  = 32'd0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = 32'd0;
    dm_wdata = 32'd0;
    mem_dout = 32'd0;

    // reset state, before any clock edge
    #3;
    chk_all_zero("rst");
    check("rst_rdata", {if_rdata, dm_rdata}, 64'd0);
    tick();
    reset = 1'b0;
    tick();

    // fetch, no contention
    if_req   = 1'b1;
    if_addr  = 32'h0040_0020;
    mem_dout = 32'h8C22_0004;
    for (int c = 1; c <= LAT; c++) begin
      tick();
      check("if_busy", {mem_cs, mem_oe, mem_we, if_valid}, 4'b1100);
      check("if_addr", mem_addr, 32'h0040_0020);
    end
    tick();
    check("if_done", {if_valid, dm_valid, mem_cs}, 3'b100);
    check("if_rdata", if_rdata, 32'h8C22_0004);
    if_req = 1'b0;
    tick();
    check("if_pulse", {if_valid, mem_cs}, 2'b00);

    // store
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h1001_0000;
    dm_wdata = 32'hDEAD_BEEF;
    mem_dout = 32'h1234_5678;
    for (int c = 1; c <= LAT; c++) begin
      tick();
      check("st_busy", {mem_cs, mem_oe, mem_we, dm_valid}, 4'b1010);
      check("st_bus", {mem_addr, mem_din}, {32'h1001_0000, 32'hDEAD_BEEF});
    end
    tick();
    check("st_done", {dm_valid, if_valid, mem_we, mem_cs}, 4'b1000);
    check("st_rdata", dm_rdata, 32'd0);
    dm_req = 1'b0;
    tick();
    check("st_pulse", {dm_valid, mem_cs}, 2'b00);

    // load
    dm_req   = 1'b1;
    dm_we    = 1'b0;
    dm_addr  = 32'h1001_0004;
    mem_dout = 32'hCAFE_F00D;
    tick();
    check("ld_busy", {mem_cs, mem_oe, mem_we}, 3'b110);
    check("ld_addr", mem_addr, 32'h1001_0004);
    for (int c = 2; c <= LAT + 1; c++) tick();
    check("ld_done", {dm_valid, if_valid}, 2'b10);
    check("ld_rdata", dm_rdata, 32'hCAFE_F00D);
    check("ld_keep_if", if_rdata, 32'h8C22_0004);
    dm_req = 1'b0;
    tick();

    // contention right after reset
    reset = 1'b1;
    tick();
    reset   = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h0000_0100;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h0000_0200;
    for (int k = 0; k < 4; k++) begin
      mem_dout   = 32'hA0 + 32'(k);
      w_exp_addr = exp_seq[k][1] ? 32'h100 : 32'h200;
      tick();
      check("rr_addr", mem_addr, w_exp_addr);
      for (int c = 2; c <= LAT + 1; c++) tick();
      check("rr_valid", {if_valid, dm_valid}, exp_seq[k]);
      if (exp_seq[k][1])
        check("rr_ifdat", if_rdata, 32'hA0 + 32'(k));
      else
        check("rr_dmdat", dm_rdata, 32'hA0 + 32'(k));
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
    chk_all_zero("rr_idle");

    // reset during cycle 2 of a store
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h1001_0008;
    dm_wdata = 32'h0BAD_F00D;
    tick();
    tick();
    check("ar_we", mem_we, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("ar_async");
    check("ar_rdata", {if_rdata, dm_rdata}, 64'd0);
    dm_req = 1'b0;
    tick();
    reset = 1'b0;
    seen_valid = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      tick();
      seen_valid = seen_valid | dm_valid | mem_we;
    end
    check("ar_novalid", seen_valid, 1'b0);

    // retried store
    dm_req = 1'b1;
    tick();
    check("rt_bus", {mem_we, mem_addr, mem_din},
          {1'b1, 32'h1001_0008, 32'h0BAD_F00D});
    for (int c = 2; c <= LAT + 1; c++) tick();
    check("rt_done", {dm_valid, mem_we}, 2'b10);
    dm_req = 1'b0;
    tick();
    check("rt_pulse", dm_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: byte-address width on all address ports.
REQ-002 SHALL have parameter MEM_LAT, default 1, legal 1..15: cycles each access holds the SRAM port before read data is sampled.
REQ-003 SHALL have clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have if_req, input, 1: instruction-fetch request, held high until if_valid.
REQ-006 SHALL have if_addr, input, ADDR_W: fetch address (PC), stable while if_req is high.
REQ-007 SHALL have if_rdata, output, 32: fetched instruction.
REQ-008 SHALL have if_valid, output, 1: one-cycle pulse, if_rdata valid.
REQ-009 SHALL have dm_req / dm_we, inputs, 1 each: data request, held until dm_valid; dm_we=1 selects write.
REQ-010 SHALL have dm_addr (ADDR_W) and dm_wdata (32), inputs: data address and write data, stable while dm_req is high.
REQ-011 SHALL have dm_rdata, output, 32, and dm_valid, output, 1: load data and one-cycle completion pulse for loads and stores.
REQ-012 SHALL have mem_cs, mem_oe, mem_we (outputs, 1), mem_addr (output, ADDR_W), mem_din (output, 32) and mem_dout (input, 32): the single shared SRAM port.

Function
REQ-013 SHALL implement states IDLE, IF_ACC and DM_ACC.
REQ-014 In IDLE with exactly one request high, SHALL enter that requester's ACC state on the next edge.
REQ-015 In IDLE with both requests high, SHALL grant the requester not served last (round-robin); the last-served flag resets to "data", so fetch wins the first contention.
REQ-016 In an ACC state, SHALL drive mem_cs=1, mem_addr from the granted port, and mem_oe=1 for fetch or loads (mem_we=0); for stores, SHALL drive mem_we=1, mem_oe=0 and mem_din=dm_wdata.
REQ-017 A 4-bit counter SHALL load 0 on entry to an ACC state and increment each cycle; on the cycle the counter equals MEM_LAT-1, the arbiter SHALL register mem_dout into the granted port's rdata and return to IDLE.
REQ-018 The granted port's valid SHALL pulse for exactly the one cycle after that return (IDLE cycle); requester latency from req to valid with no contention SHALL be MEM_LAT+1 cycles.
REQ-019 if_rdata and dm_rdata SHALL hold their last captured value until the next capture for that port; stores SHALL NOT modify dm_rdata.
REQ-020 The IDLE cycle that carries a valid pulse SHALL also evaluate new requests (REQ-014/015), so back-to-back throughput is one access per MEM_LAT+1 cycles.
REQ-021 A requester that is denied SHALL be granted no later than the next arbitration, bounding wait to MEM_LAT+1 cycles.
REQ-022 In IDLE, all mem_* outputs SHALL be 0.
REQ-023 Deassertion of a request during its own access SHALL NOT abort the access; the valid pulse is still issued.

Reset
REQ-024 Reset SHALL force IDLE, counter 0, last-served=data, if_rdata=dm_rdata=0, if_valid=dm_valid=0 and all mem_* outputs 0, independent of clk.
REQ-025 Reset asserted mid-access SHALL abort the access with no valid pulse and no further mem_we; the first grant after reset release SHALL follow REQ-014/015.

Configuration
REQ-026 With macro MEM_ARBITER_DATA_PRIORITY_EN defined, SHALL replace round-robin with fixed priority: dm_req always wins simultaneous contention, and REQ-021 applies only to the data port.
REQ-027 Without MEM_ARBITER_DATA_PRIORITY_EN, SHALL use the round-robin of REQ-015.

Verification
REQ-028 With MEM_LAT=1, hold if_req with if_addr=0x00400020 and mem_dout=0x8C220004 -> if_valid high exactly at cycle 2, if_rdata=0x8C220004.
REQ-029 With MEM_LAT=3, drive dm_req with dm_we=1, dm_addr=0x10010000 and dm_wdata=0xDEADBEEF -> mem_we=1 for 3 cycles at 0x10010000, dm_valid pulses once, dm_rdata unchanged.
REQ-030 Raise if_req and dm_req together after reset and hold both -> grants alternate IF, DM, IF, DM; no valid is ever two consecutive accesses to the same port.
REQ-031 With MEM_ARBITER_DATA_PRIORITY_EN defined, repeat REQ-030 -> DM granted first and again each time both requests are pending.
REQ-032 With MEM_LAT=4, assert reset during cycle 2 of a store -> mem_we drops asynchronously, no dm_valid pulse, all outputs 0, and a retried request completes normally.
